// File: rtl/common_dffram_mwmr_pkg.sv
// Shared constants and size helpers for the multi-write/multi-read DFF RAM.
// Optional build macro: COMMON_DFFRAM_MWMR_BYPASS_EN (write-first read forwarding).
package common_dffram_mwmr_pkg;

  localparam int WR_PORTS_MAX = 4;
  localparam int RD_PORTS_MAX = 8;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

`ifdef COMMON_DFFRAM_MWMR_BYPASS_EN
  localparam rdw_mode_e RDW_MODE = RDW_WRITE_FIRST;
`else
  localparam rdw_mode_e RDW_MODE = RDW_READ_FIRST;
`endif

  function automatic int ram_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int ram_lanes(input int data_width, input int lane_width);
    return data_width / lane_width;
  endfunction

  // Low bit of packed slice idx when every slice is width bits wide.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/common_dffram_mwmr_if.sv
// Write/read port bundle for common_dffram_mwmr; all multi-port fields are packed, port p in slice p.
interface common_dffram_mwmr_if
  import common_dffram_mwmr_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 4,
  parameter int RAM_LANE_WIDTH = 8,
  parameter int WR_PORTS       = 2,
  parameter int RD_PORTS       = 2
);
  localparam int LANES = ram_lanes(RAM_DATA_WIDTH, RAM_LANE_WIDTH);

  logic [WR_PORTS-1:0]                wen;
  logic [WR_PORTS*RAM_ADDR_WIDTH-1:0] waddr;
  logic [WR_PORTS*LANES-1:0]          wstrb;
  logic [WR_PORTS*RAM_DATA_WIDTH-1:0] wdata;
  logic [RD_PORTS-1:0]                ren;
  logic [RD_PORTS*RAM_ADDR_WIDTH-1:0] raddr;
  logic [RD_PORTS*RAM_DATA_WIDTH-1:0] rdata;
  logic [RD_PORTS-1:0]                rvalid;
  logic                               wcollide;

  modport master (
    output wen, waddr, wstrb, wdata, ren, raddr,
    input  rdata, rvalid, wcollide
  );

  modport slave (
    input  wen, waddr, wstrb, wdata, ren, raddr,
    output rdata, rvalid, wcollide
  );

endinterface

// File: rtl/common_dffram_lane_wsel.sv
// Resolves the write requests aimed at one entry lane: highest port index wins,
// and two or more simultaneous requests flag a collision.
module common_dffram_lane_wsel #(
  parameter int WR_PORTS   = 2,
  parameter int LANE_WIDTH = 8
) (
  input  logic [WR_PORTS-1:0]            req_i,
  input  logic [WR_PORTS*LANE_WIDTH-1:0] data_i,
  output logic                           we_o,
  output logic [LANE_WIDTH-1:0]          data_o,
  output logic                           collide_o
);

  logic seen;

  always_comb begin
    we_o      = |req_i;
    data_o    = '0;
    collide_o = 1'b0;
    seen      = 1'b0;
    // Ascending scan so later (higher) ports overwrite earlier winners.
    for (int p = 0; p < WR_PORTS; p++) begin
      if (req_i[p]) begin
        data_o = data_i[p*LANE_WIDTH +: LANE_WIDTH];
        if (seen) begin
          collide_o = 1'b1;
        end
        seen = 1'b1;
      end
    end
  end

endmodule

// File: rtl/common_dffram_mwmr.sv
// Parametrised DFF RAM: WR_PORTS lane-strobed writes, RD_PORTS registered reads, sticky collision flag.
// Define COMMON_DFFRAM_MWMR_BYPASS_EN for write-first forwarding; default is read-first.
module common_dffram_mwmr
  import common_dffram_mwmr_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 4,
  parameter int RAM_LANE_WIDTH = 8,
  parameter int WR_PORTS       = 2,
  parameter int RD_PORTS       = 2,
  parameter logic [(1<<RAM_ADDR_WIDTH)*RAM_DATA_WIDTH-1:0] RAM_RESET_VALUE = '0
) (
  input logic                  clk,
  input logic                  rst_n,
  common_dffram_mwmr_if.slave  bus
);

  localparam int DEPTH = ram_depth(RAM_ADDR_WIDTH);
  localparam int LANES = ram_lanes(RAM_DATA_WIDTH, RAM_LANE_WIDTH);
  localparam int DW    = RAM_DATA_WIDTH;
  localparam int AW    = RAM_ADDR_WIDTH;
  localparam int LW    = RAM_LANE_WIDTH;

  logic [DEPTH*DW-1:0]    mem_q;
  logic [DEPTH*DW-1:0]    mem_d;
  logic [DEPTH*LANES-1:0] lane_collide;
  logic [DW-1:0]          mem_q_view [DEPTH];
  logic [DW-1:0]          rd_src     [RD_PORTS];

  logic [RD_PORTS*DW-1:0] rdata_q, rdata_d;
  logic [RD_PORTS-1:0]    rvalid_q, rvalid_d;
  logic                   wcollide_q, wcollide_d;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
      logic [WR_PORTS-1:0]    req;
      logic [WR_PORTS*LW-1:0] lane_data;
      logic                   lane_we;
      logic [LW-1:0]          lane_wd;

      for (genvar gp = 0; gp < WR_PORTS; gp++) begin : g_port
        assign req[gp] = bus.wen[gp]
                       & bus.wstrb[gp*LANES + gl]
                       & (bus.waddr[gp*AW +: AW] == AW'(gi));
        assign lane_data[gp*LW +: LW] = bus.wdata[gp*DW + gl*LW +: LW];
      end

      common_dffram_lane_wsel #(
        .WR_PORTS   (WR_PORTS),
        .LANE_WIDTH (LW)
      ) u_wsel (
        .req_i     (req),
        .data_i    (lane_data),
        .we_o      (lane_we),
        .data_o    (lane_wd),
        .collide_o (lane_collide[gi*LANES + gl])
      );

      assign mem_d[gi*DW + gl*LW +: LW] = lane_we ? lane_wd : mem_q[gi*DW + gl*LW +: LW];
    end

    assign mem_q_view[gi] = mem_q[slice_lo(gi, DW) +: DW];
  end

`ifdef COMMON_DFFRAM_MWMR_BYPASS_EN
  // mem_d is already the lane-merged, priority-resolved post-edge image.
  logic [DW-1:0] mem_d_view [DEPTH];
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd_view
    assign mem_d_view[gi] = mem_d[slice_lo(gi, DW) +: DW];
  end
  for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd_src
    assign rd_src[gi] = mem_d_view[bus.raddr[gi*AW +: AW]];
  end
`else
  for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd_src
    assign rd_src[gi] = mem_q_view[bus.raddr[gi*AW +: AW]];
  end
`endif

  always_comb begin
    rdata_d    = rdata_q;
    rvalid_d   = bus.ren;
    wcollide_d = wcollide_q | (|lane_collide);
    for (int q = 0; q < RD_PORTS; q++) begin
      if (bus.ren[q]) begin
        rdata_d[q*DW +: DW] = rd_src[q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= RAM_RESET_VALUE;
      rdata_q    <= '0;
      rvalid_q   <= '0;
      wcollide_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      wcollide_q <= wcollide_d;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.wcollide = wcollide_q;

endmodule

// File: doc/common_dffram_mwmr.md
Name: common_dffram_mwmr

Overview:
Parametrised DFF-based RAM. It is the multi-port successor to the simple 2-address 1W1R DFF RAM.
- N write ports, each with a per-lane byte-enable.
- M read ports, each with registered output and valid.
- Deterministic collision priority and a sticky collision flag.
- Used for register files, small tag arrays and queue storage in the core.

Parameters:
- RAM_DATA_WIDTH, 32: data bits per entry.
- RAM_ADDR_WIDTH, 4: address bits. Depth is 1<<RAM_ADDR_WIDTH.
- RAM_LANE_WIDTH, 8: bits per write lane. Must divide RAM_DATA_WIDTH. LANES = RAM_DATA_WIDTH/RAM_LANE_WIDTH.
- WR_PORTS, 2: number of write ports. Range 1..4.
- RD_PORTS, 2: number of read ports. Range 1..8.
- RAM_RESET_VALUE, all-zero: flat DEPTH*RAM_DATA_WIDTH initial image. Entry i occupies bits [i*RAM_DATA_WIDTH +: RAM_DATA_WIDTH].

Ports:
- clk, in, 1: clock. All state changes on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- wen, in, WR_PORTS: write enable per port.
- waddr, in, WR_PORTS*RAM_ADDR_WIDTH: packed write addresses. Port p is slice p.
- wstrb, in, WR_PORTS*LANES: per-port lane enables.
- wdata, in, WR_PORTS*RAM_DATA_WIDTH: packed write data.
- ren, in, RD_PORTS: read request per port.
- raddr, in, RD_PORTS*RAM_ADDR_WIDTH: packed read addresses.
- rdata, out, RD_PORTS*RAM_DATA_WIDTH: registered read data.
- rvalid, out, RD_PORTS: high in the cycle after the matching ren.
- wcollide, out, 1: sticky flag. Set when two write ports hit the same entry and the same lane in one cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - Array loads RAM_RESET_VALUE.
  - rdata = 0, rvalid = 0, wcollide = 0.
  - Held while reset is low. The first write is accepted on the first edge after deassertion.
- Write, lane-granular:
  - Entry e, lane l updates at the edge when wen[p] & wstrb[p*LANES+l] & waddr[p]==e for some p.
  - Lanes without a strobe keep their old value.
  - wen=1 with wstrb=0 is a no-op and is not a collision.
- Write priority: if several ports hit the same entry and lane, the highest port index wins. The resolution is per lane, so different lanes from different ports merge into one entry.
- wcollide:
  - Set at the edge after any same-entry, same-lane multi-port write.
  - Cleared only by reset.
  - Different lanes at the same address do not set it.
- Read:
  - Latency is 1 cycle. On the edge where ren[q]=1, rdata[q] captures the entry at raddr[q] and rvalid[q] goes to 1.
  - If ren[q]=0, rvalid[q] goes to 0 and rdata[q] holds its last value.
  - Read ports are independent; any number may address the same entry.
- Read-during-write, same cycle and same address: read-first. rdata returns the pre-write contents. See the optional feature for the alternative.
- Back-to-back:
  - A write at edge k is visible to a read issued in cycle k+1.
  - Continuous ren gives rvalid high every cycle.
- Wrap-around: none. Addresses cover the full power-of-two depth, so no out-of-range case exists.
- Reset mid-operation: pending reads are lost (rvalid forced to 0), writes in that cycle are dropped, and the array returns to the reset image.

Optional Feature:
Macro COMMON_DFFRAM_MWMR_BYPASS_EN.
- Defined: write-first forwarding. A read in the same cycle as a write to the same address captures the merged new value. Per lane, strobed lanes take the winning port's data and unstrobed lanes take the old data. Priority matches the array, so rdata equals the post-edge array contents.
- Undefined: read-first, as specified above. The forwarding mux is absent.
- Array update, rvalid and wcollide are identical in both builds.

Decomposition:
- Shared header common_dffram_defs.vh holds:
  - the DEPTH and LANES derivation macros;
  - the packed-slice index macros;
  - the maximum port-count constants.
- One sub-module, common_dffram_lane_wsel: per entry and per lane, it resolves the WR_PORTS requests to a write enable, the winning data and a collision bit. It is instantiated DEPTH*LANES times and reused by the bypass path.
- The top level holds the storage flops, the read registers and the wcollide flop.

Test Plan:
- Reset: RAM_RESET_VALUE entry 3 = 0xDEADBEEF, reset released. Read addr 3 on port 0 → next cycle rvalid[0]=1, rdata[0]=0xDEADBEEF. Before any ren, rvalid=0 and wcollide=0.
- Lane merge: port0 writes addr 5 = 0x11223344 with wstrb=0011, port1 writes addr 5 = 0xAABBCCDD with wstrb=1100, same cycle. A later read of addr 5 gives 0xAABB3344 and wcollide stays 0.
- Collision priority: both ports write addr 2 with wstrb=1111, port0 = 0x1 and port1 = 0x2. A read gives 0x2 and wcollide=1 from the next edge until reset.
- Read-during-write: addr 7 holds 0x5. Write 0x9 to addr 7 and read addr 7 in the same cycle → rdata=0x5 without the macro, 0x9 with it. The following read gives 0x9 in both builds.
- Multi-read: ports 0 and 1 both read addr 4 (value 0xCAFE) for 3 consecutive cycles → both rvalid high for 3 cycles with identical rdata. ren deasserted → rvalid=0 next cycle and rdata held at 0xCAFE.
- Async reset mid-stream: assert reset between edges during writes and reads → rvalid, rdata and wcollide clear immediately and the array returns to the reset image.
